// File: rtl/exu_wb_arbiter.sv
// Execute-stage write-back arbiter: serialises ALU/BJP/CSR/MULDIV/MEM results onto
// the single register-file write port using fixed priority with anti-starvation promotion.
module exu_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wb_valid_i,
    input  logic [4:0]  alu_wb_rd_i,
    input  logic [31:0] alu_wb_data_i,
    output logic        alu_wb_ready_o,
    input  logic        bjp_wb_valid_i,
    input  logic [4:0]  bjp_wb_rd_i,
    input  logic [31:0] bjp_wb_data_i,
    output logic        bjp_wb_ready_o,
    input  logic        csr_wb_valid_i,
    input  logic [4:0]  csr_wb_rd_i,
    input  logic [31:0] csr_wb_data_i,
    output logic        csr_wb_ready_o,
    input  logic        muldiv_wb_valid_i,
    input  logic [4:0]  muldiv_wb_rd_i,
    input  logic [31:0] muldiv_wb_data_i,
    output logic        muldiv_wb_ready_o,
    input  logic        mem_wb_valid_i,
    input  logic [4:0]  mem_wb_rd_i,
    input  logic [31:0] mem_wb_data_i,
    output logic        mem_wb_ready_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic [2:0]  wb_src_o
);
    localparam int unsigned     NSRC  = 5;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_ALU    = 3'd1,
        SRC_BJP    = 3'd2,
        SRC_CSR    = 3'd3,
        SRC_MULDIV = 3'd4,
        SRC_MEM    = 3'd5
    } src_e;

    logic [NSRC-1:0]  valid;
    logic [NSRC-1:0]  starved;
    logic [NSRC-1:0]  cand;
    logic [NSRC-1:0]  grant;
    logic [4:0]       rd   [NSRC];
    logic [31:0]      data [NSRC];
    logic [CNT_W-1:0] cnt_q [NSRC];
    logic [CNT_W-1:0] cnt_d [NSRC];

    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    src_e        sel_src;

    logic        reg_we_q;
    logic [4:0]  reg_waddr_q;
    logic [31:0] reg_wdata_q;
    src_e        wb_src_q;

    // Index order is ascending priority: alu=0 ... mem=4.
    assign valid   = {mem_wb_valid_i, muldiv_wb_valid_i, csr_wb_valid_i, bjp_wb_valid_i, alu_wb_valid_i};
    assign rd[0]   = alu_wb_rd_i;
    assign rd[1]   = bjp_wb_rd_i;
    assign rd[2]   = csr_wb_rd_i;
    assign rd[3]   = muldiv_wb_rd_i;
    assign rd[4]   = mem_wb_rd_i;
    assign data[0] = alu_wb_data_i;
    assign data[1] = bjp_wb_data_i;
    assign data[2] = csr_wb_data_i;
    assign data[3] = muldiv_wb_data_i;
    assign data[4] = mem_wb_data_i;

    always_comb begin
        starved = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            starved[i] = valid[i] && (cnt_q[i] == LIMIT);
        end
        // Starved requesters form their own candidate set, shadowing everyone else.
        cand  = (|starved) ? starved : valid;
        grant = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (cand[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        if (rst) begin
            grant = '0;
        end
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        sel_src  = SRC_NONE;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                sel_rd   = rd[i];
                sel_data = data[i];
                sel_src  = src_e'(3'(i + 1));
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            cnt_d[i] = '0;
            if (valid[i] && !grant[i]) begin
                cnt_d[i] = (cnt_q[i] == LIMIT) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                cnt_q[i] <= '0;
            end
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            wb_src_q    <= SRC_NONE;
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (|grant) begin
                reg_we_q    <= (sel_rd != 5'd0);
                reg_waddr_q <= sel_rd;
                reg_wdata_q <= sel_data;
                wb_src_q    <= sel_src;
            end else begin
                reg_we_q <= 1'b0;
                wb_src_q <= SRC_NONE;
            end
        end
    end

    assign alu_wb_ready_o    = grant[0];
    assign bjp_wb_ready_o    = grant[1];
    assign csr_wb_ready_o    = grant[2];
    assign muldiv_wb_ready_o = grant[3];
    assign mem_wb_ready_o    = grant[4];

    assign reg_we_o    = reg_we_q;
    assign reg_waddr_o = reg_waddr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign wb_src_o    = wb_src_q;
endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Bench for exu_wb_arbiter: directed scenarios followed by random traffic, all checked
// against a request-list model of the priority and starvation rules.
module tb_exu_wb_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v   [5];
    logic [4:0]  rdv [5];
    logic [31:0] dv  [5];
    logic [4:0]  rdy;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [2:0]  wb_src;

    int checks   = 0;
    int failures = 0;

    // Model state: per-source consecutive-stall counts, expected outputs, last winner.
    int          mcnt [5];
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_src;
    int          last_g;

    always #5 clk = ~clk;

    exu_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_wb_valid_i    (v[0]),
        .alu_wb_rd_i       (rdv[0]),
        .alu_wb_data_i     (dv[0]),
        .alu_wb_ready_o    (rdy[0]),
        .bjp_wb_valid_i    (v[1]),
        .bjp_wb_rd_i       (rdv[1]),
        .bjp_wb_data_i     (dv[1]),
        .bjp_wb_ready_o    (rdy[1]),
        .csr_wb_valid_i    (v[2]),
        .csr_wb_rd_i       (rdv[2]),
        .csr_wb_data_i     (dv[2]),
        .csr_wb_ready_o    (rdy[2]),
        .muldiv_wb_valid_i (v[3]),
        .muldiv_wb_rd_i    (rdv[3]),
        .muldiv_wb_data_i  (dv[3]),
        .muldiv_wb_ready_o (rdy[3]),
        .mem_wb_valid_i    (v[4]),
        .mem_wb_rd_i       (rdv[4]),
        .mem_wb_data_i     (dv[4]),
        .mem_wb_ready_o    (rdy[4]),
        .reg_we_o          (reg_we),
        .reg_waddr_o       (reg_waddr),
        .reg_wdata_o       (reg_wdata),
        .wb_src_o          (wb_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 5; s++) mcnt[s] = 0;
        e_we   = 1'b0;
        e_addr = '0;
        e_data = '0;
        e_src  = '0;
        last_g = -1;
    endtask

    // Winner: first starved requester in mem..alu order, else first requester in that order.
    function automatic int model_pick();
        int order [5] = '{4, 3, 2, 1, 0};
        foreach (order[k]) if (v[order[k]] && mcnt[order[k]] == LIMIT) return order[k];
        foreach (order[k]) if (v[order[k]]) return order[k];
        return -1;
    endfunction

    // Called just after a falling edge with inputs set for the coming rising edge.
    task automatic cycle();
        int g;
        #1;
        g = model_pick();
        for (int s = 0; s < 5; s++) chk($sformatf("ready[%0d]", s), 32'(rdy[s]), 32'(g == s));
        for (int s = 0; s < 5; s++) begin
            if (v[s] && g != s) mcnt[s] = (mcnt[s] + 1 > LIMIT) ? LIMIT : mcnt[s] + 1;
            else                mcnt[s] = 0;
        end
        if (g >= 0) begin
            e_we   = (rdv[g] != 5'd0);
            e_addr = rdv[g];
            e_data = dv[g];
            e_src  = 3'(g + 1);
        end else begin
            e_we  = 1'b0;
            e_src = '0;
        end
        last_g = g;
        @(negedge clk);
        chk("reg_we", 32'(reg_we), 32'(e_we));
        chk("wb_src", 32'(wb_src), 32'(e_src));
        chk("reg_waddr", 32'(reg_waddr), 32'(e_addr));
        chk("reg_wdata", reg_wdata, e_data);
    endtask

    task automatic req(input int s, input logic [4:0] r, input logic [31:0] d);
        v[s]   = 1'b1;
        rdv[s] = r;
        dv[s]  = d;
    endtask

    task automatic idle();
        for (int s = 0; s < 5; s++) v[s] = 1'b0;
        cycle();
    endtask

    initial begin
        for (int s = 0; s < 5; s++) begin
            v[s] = 1'b0; rdv[s] = '0; dv[s] = '0;
        end
        model_reset();

        // Reset state, with a request pending that must not see ready.
        @(negedge clk);
        @(negedge clk);
        req(0, 5'd1, 32'h1);
        #1;
        chk("rst_alu_ready", 32'(rdy[0]), 32'd0);
        chk("rst_we", 32'(reg_we), 32'd0);
        chk("rst_src", 32'(wb_src), 32'd0);
        chk("rst_waddr", 32'(reg_waddr), 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Single ALU write.
        req(0, 5'd5, 32'h0000_1234);
        #1 chk("t1_alu_ready", 32'(rdy[0]), 32'd1);
        cycle();
        v[0] = 1'b0;
        chk("t1_we", 32'(reg_we), 32'd1);
        chk("t1_waddr", 32'(reg_waddr), 32'd5);
        chk("t1_wdata", reg_wdata, 32'h1234);
        chk("t1_src", 32'(wb_src), 32'd1);
        cycle();
        chk("t1_we_off", 32'(reg_we), 32'd0);

        // Collision mem vs alu.
        req(4, 5'd3, 32'hAA);
        req(0, 5'd4, 32'hBB);
        #1 chk("t2_mem_ready", 32'(rdy[4]), 32'd1);
        chk("t2_alu_ready", 32'(rdy[0]), 32'd0);
        cycle();
        v[4] = 1'b0;
        chk("t2_wdata1", reg_wdata, 32'hAA);
        #1 chk("t2_alu_ready2", 32'(rdy[0]), 32'd1);
        cycle();
        v[0] = 1'b0;
        chk("t2_waddr2", 32'(reg_waddr), 32'd4);
        chk("t2_wdata2", reg_wdata, 32'hBB);
        idle();

        // Starvation: alu held while mem streams.
        req(0, 5'd7, 32'h77);
        for (int n = 0; n < 4; n++) begin
            req(4, 5'd9, 32'(100 + n));
            #1 chk("t3_alu_stall", 32'(rdy[0]), 32'd0);
            cycle();
        end
        req(4, 5'd9, 32'd200);
        #1 chk("t3_alu_promoted", 32'(rdy[0]), 32'd1);
        chk("t3_mem_stalled", 32'(rdy[4]), 32'd0);
        cycle();
        v[0] = 1'b0;
        chk("t3_alu_data", reg_wdata, 32'h77);
        cycle();
        chk("t3_mem_data", reg_wdata, 32'd200);
        idle();

        // x0 write from BJP.
        req(1, 5'd0, 32'h8000_0004);
        #1 chk("t4_bjp_ready", 32'(rdy[1]), 32'd1);
        cycle();
        v[1] = 1'b0;
        chk("t4_we", 32'(reg_we), 32'd0);
        chk("t4_src", 32'(wb_src), 32'd2);
        idle();

        // Two starved sources (csr, alu) against muldiv.
        req(2, 5'd10, 32'hC5);
        req(0, 5'd11, 32'hA1);
        for (int n = 0; n < 4; n++) begin
            req(4, 5'd12, 32'(300 + n));
            cycle();
        end
        v[4] = 1'b0;
        req(3, 5'd13, 32'hD3);
        #1 chk("t5_csr_first", 32'(rdy[2]), 32'd1);
        cycle();
        v[2] = 1'b0;
        #1 chk("t5_alu_second", 32'(rdy[0]), 32'd1);
        cycle();
        v[0] = 1'b0;
        #1 chk("t5_muldiv_third", 32'(rdy[3]), 32'd1);
        cycle();
        v[3] = 1'b0;
        idle();

        // Asynchronous reset while a write is on the outputs.
        req(0, 5'd5, 32'h11);
        cycle();
        req(0, 5'd6, 32'h22);
        #2 rst = 1'b1;
        #1;
        chk("t6_we", 32'(reg_we), 32'd0);
        chk("t6_src", 32'(wb_src), 32'd0);
        chk("t6_waddr", 32'(reg_waddr), 32'd0);
        chk("t6_ready", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1 chk("t6_after_ready", 32'(rdy[0]), 32'd1);
        cycle();
        v[0] = 1'b0;
        chk("t6_after_data", reg_wdata, 32'h22);
        idle();

        // Random traffic honouring the hold-until-ready contract, with rare drops.
        for (int c = 0; c < 2000; c++) begin
            for (int s = 0; s < 5; s++) begin
                if (v[s] && last_g == s) begin
                    if ($urandom_range(0, 1) == 0) req(s, 5'($urandom), $urandom);
                    else v[s] = 1'b0;
                end else if (v[s]) begin
                    if ($urandom_range(0, 31) == 0) v[s] = 1'b0;
                end else if ($urandom_range(0, 9) < 4) begin
                    req(s, 5'($urandom), $urandom);
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exu_wb_arbiter.md
Name: exu_wb_arbiter

Overview:
- Return path of the execute stage. Collects result write-backs from the ALU, BJP (link address), CSR, MULDIV and MEM (load data) units and serialises them onto the single register-file write port.
- Each source uses a valid/ready handshake. The arbiter combines fixed priority with an anti-starvation override.
- The register-file write is registered, so it occurs one cycle after acceptance.

Parameters:
- STARVE_LIMIT, 4: number of consecutive stalled cycles after which a waiting source is promoted to top priority (legal range 1..15).
- CNT_W, 4: width of each per-source wait counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_wb_valid_i  input  1  ALU result valid.
- alu_wb_rd_i  input  5  ALU destination register.
- alu_wb_data_i  input  32  ALU result.
- alu_wb_ready_o  output  1  ALU result accepted this cycle.
- bjp_wb_valid_i / bjp_wb_rd_i / bjp_wb_data_i / bjp_wb_ready_o  in/in/in/out  1/5/32/1  BJP link write (JAL/JALR).
- csr_wb_valid_i / csr_wb_rd_i / csr_wb_data_i / csr_wb_ready_o  in/in/in/out  1/5/32/1  CSR old-value write.
- muldiv_wb_valid_i / muldiv_wb_rd_i / muldiv_wb_data_i / muldiv_wb_ready_o  in/in/in/out  1/5/32/1  MULDIV result.
- mem_wb_valid_i / mem_wb_rd_i / mem_wb_data_i / mem_wb_ready_o  in/in/in/out  1/5/32/1  load data.
- reg_we_o  output  1  register-file write enable (registered).
- reg_waddr_o  output  5  register-file write address (registered).
- reg_wdata_o  output  32  register-file write data (registered).
- wb_src_o  output  3  source of the current write: 0 none, 1 alu, 2 bjp, 3 csr, 4 muldiv, 5 mem (registered).

Behaviour:
- Reset (async, rst=1):
  - reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, wb_src_o=0.
  - All wait counters cleared to 0.
  - All *_ready_o low while rst is high.
- Source contract: once *_valid_i rises, the source holds valid, rd and data stable until it sees ready. The arbiter does not check this.
- Grant is combinational and one-hot, at most one source per cycle. *_ready_o = grant of that source.
- Acceptance occurs when valid & ready are both high in the same cycle.
- Priority:
  - Base fixed order: mem > muldiv > csr > bjp > alu.
  - Starved source: one whose wait counter equals STARVE_LIMIT and whose valid is high.
  - Any starved source preempts all non-starved sources.
  - Among several starved sources, the base fixed order applies.
- Wait counter, per source, evaluated each cycle:
  - valid & !ready: increment, saturating at STARVE_LIMIT.
  - Acceptance, or valid low: clear to 0.
- Output register, in the cycle after an acceptance:
  - reg_waddr_o = accepted rd; reg_wdata_o = accepted data; wb_src_o = source code.
  - reg_we_o = 1 only if rd != 0.
  - rd == 0: the handshake still completes and wb_src_o still reports the source, but reg_we_o = 0.
- No acceptance in a cycle: next cycle reg_we_o=0 and wb_src_o=0. reg_waddr_o and reg_wdata_o hold their last values.
- Throughput: one write-back per cycle, back to back. Latency is exactly 1 cycle from acceptance to reg_we_o.
- Ready never depends on the output register, so there is no back-pressure from the register file.
- A source whose valid drops without acceptance (protocol violation) is ignored. Its counter clears.
- Reset asserted mid-operation: outputs and counters clear immediately (asynchronously). A pending, not-yet-registered write is lost.

Test Plan:
- Single source: ALU valid, rd=5, data=0x0000_1234 at cycle N → alu_wb_ready_o=1 at N; at N+1 reg_we_o=1, reg_waddr_o=5, reg_wdata_o=0x1234, wb_src_o=1; at N+2 reg_we_o=0.
- Collision: mem (rd=3, data=0xAA) and alu (rd=4, data=0xBB) both valid at N → mem granted at N; alu granted at N+1; writes of 3/0xAA and 4/0xBB appear at N+1 and N+2.
- Starvation (STARVE_LIMIT=4): alu held valid, mem valid continuously with new data each cycle → alu ready stays low for 4 cycles, then rises on the 5th cycle despite mem valid; mem is stalled that cycle, and its counter becomes 1.
- x0 write: bjp valid, rd=0, data=0x8000_0004 → bjp_wb_ready_o=1; next cycle reg_we_o=0, wb_src_o=2.
- Two starved sources: csr and alu both held at counter=4 while muldiv is valid → csr granted first, then alu, then muldiv.
- Async reset: assert rst mid-cycle while reg_we_o=1 → reg_we_o, wb_src_o and all ready outputs go to 0 immediately. After deassert, a pending alu request is granted on the first clock edge.
